// File: rtl/sys_counter_csr_pkg.sv
// Shared constants and types for the CSR-to-system-counter sequencer.
// Holds the CSR address map, counter select codes, op codes, FSM states and the RMW helper.
package sys_counter_csr_pkg;

    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_TIME      = 12'hC01;
    localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [11:0] CUSTOM_BASE_DEFAULT = 12'h7C0;
    localparam logic [11:0] CUSTOM_WINDOW_SIZE  = 12'd6;

    typedef enum logic [3:0] {
        SEL_CYCLE_LO   = 4'b0000,
        SEL_CYCLE_HI   = 4'b0001,
        SEL_IDLE       = 4'b0010,
        SEL_INSTRET_LO = 4'b0100,
        SEL_INSTRET_HI = 4'b0101,
        SEL_TIME_LO    = 4'b1000,
        SEL_TIME_HI    = 4'b1001,
        SEL_TIMECMP_LO = 4'b1010,
        SEL_TIMECMP_HI = 4'b1011,
        SEL_TICK_CNT   = 4'b1100,
        SEL_TICK_LIMIT = 4'b1101
    } csr_sel_e;

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_RW      = 2'b01,
        OP_RS      = 2'b10,
        OP_RC      = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    function automatic logic [31:0] csr_rmw(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
        case (op)
            OP_RW:   return wdata;
            OP_RS:   return old_val | wdata;
            OP_RC:   return old_val & ~wdata;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/sys_counter_csr_decode.sv
// Combinational CSR address/op decoder: maps a 12-bit CSR address to a counter select code
// and flags whether the access is writable and whether it must trap as illegal.
module sys_counter_csr_decode
    import sys_counter_csr_pkg::*;
#(
    parameter logic [11:0] CUSTOM_BASE = CUSTOM_BASE_DEFAULT,
    parameter bit          USER_RO_EN  = 1'b1
) (
    input  logic [11:0] addr_i,
    input  logic [1:0]  op_i,
    input  logic        src_zero_i,
    output logic [3:0]  sel_o,
    output logic        writable_o,
    output logic        illegal_o
);

    logic        mapped;
    logic        c_range;
    logic [11:0] custom_off;

    assign custom_off = addr_i - CUSTOM_BASE;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        sel_o      = SEL_IDLE;
        mapped     = 1'b1;
        writable_o = 1'b1;
        c_range    = 1'b0;
        case (addr_i)
            ADDR_MCYCLE:    sel_o = SEL_CYCLE_LO;
            ADDR_MCYCLEH:   sel_o = SEL_CYCLE_HI;
            ADDR_MINSTRET:  sel_o = SEL_INSTRET_LO;
            ADDR_MINSTRETH: sel_o = SEL_INSTRET_HI;
            ADDR_CYCLE:     begin sel_o = SEL_CYCLE_LO;   writable_o = 1'b0; c_range = 1'b1; end
            ADDR_CYCLEH:    begin sel_o = SEL_CYCLE_HI;   writable_o = 1'b0; c_range = 1'b1; end
            ADDR_TIME:      begin sel_o = SEL_TIME_LO;    writable_o = 1'b0; c_range = 1'b1; end
            ADDR_TIMEH:     begin sel_o = SEL_TIME_HI;    writable_o = 1'b0; c_range = 1'b1; end
            ADDR_INSTRET:   begin sel_o = SEL_INSTRET_LO; writable_o = 1'b0; c_range = 1'b1; end
            ADDR_INSTRETH:  begin sel_o = SEL_INSTRET_HI; writable_o = 1'b0; c_range = 1'b1; end
            default: begin
                if (custom_off < CUSTOM_WINDOW_SIZE) begin
                    case (custom_off[2:0])
                        3'd0:    sel_o = SEL_TIMECMP_LO;
                        3'd1:    sel_o = SEL_TIMECMP_HI;
                        3'd2:    sel_o = SEL_TIME_LO;
                        3'd3:    sel_o = SEL_TIME_HI;
                        3'd4:    sel_o = SEL_TICK_CNT;
                        default: sel_o = SEL_TICK_LIMIT;
                    endcase
                end else begin
                    mapped     = 1'b0;
                    writable_o = 1'b0;
                end
            end
        endcase
    end

    // Read-only aliases stay legal only for pure reads (RS/RC with a zero source).
    assign illegal_o = !mapped
                    || (op_i == OP_ILLEGAL)
                    || (!writable_o && ((op_i == OP_RW) || !src_zero_i))
                    || (c_range && !USER_RO_EN);

endmodule

// File: rtl/sys_counter_csr_ctrl.sv
// Sequencer between the CSR execute stage and the system counter block: one request in flight,
// select -> registered read -> optional single write strobe -> response with the old value.
module sys_counter_csr_ctrl
    import sys_counter_csr_pkg::*;
#(
    parameter logic [11:0] CUSTOM_BASE = CUSTOM_BASE_DEFAULT,
    parameter bit          USER_RO_EN  = 1'b1
) (
    input  logic        proc_clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_src_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal,
    input  logic        freeze,
    output logic [3:0]  count_sel,
    input  logic [31:0] count,
    output logic [3:0]  wr_sel,
    output logic [31:0] csr_wrdata,
    output logic        csr_wr_en
);

    state_e      state_q;
    csr_op_e     op_q;
    logic [3:0]  sel_q;
    logic [31:0] wdata_q;
    logic        src_zero_q;
    logic        writable_q;
    logic [31:0] old_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_illegal_q;
    logic [3:0]  count_sel_q;
    logic [3:0]  wr_sel_q;
    logic [31:0] csr_wrdata_q;
    logic        csr_wr_en_q;

    logic [3:0]  dec_sel;
    logic        dec_writable;
    logic        dec_illegal;
    logic        write_needed;
    logic [31:0] wr_value_d;

    sys_counter_csr_decode #(
        .CUSTOM_BASE (CUSTOM_BASE),
        .USER_RO_EN  (USER_RO_EN)
    ) u_decode (
        .addr_i     (req_addr),
        .op_i       (req_op),
        .src_zero_i (req_src_zero),
        .sel_o      (dec_sel),
        .writable_o (dec_writable),
        .illegal_o  (dec_illegal)
    );

    assign write_needed = writable_q && ((op_q == OP_RW) || !src_zero_q);
    assign wr_value_d   = csr_rmw(op_q, count, wdata_q);

    always_ff @(posedge proc_clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_ILLEGAL;
            sel_q         <= SEL_IDLE;
            wdata_q       <= '0;
            src_zero_q    <= 1'b0;
            writable_q    <= 1'b0;
            old_q         <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            count_sel_q   <= SEL_IDLE;
            wr_sel_q      <= SEL_IDLE;
            csr_wrdata_q  <= '0;
            csr_wr_en_q   <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q   <= 1'b0;
                        op_q          <= csr_op_e'(req_op);
                        sel_q         <= dec_sel;
                        wdata_q       <= req_wdata;
                        src_zero_q    <= req_src_zero;
                        writable_q    <= dec_writable;
                        rsp_illegal_q <= dec_illegal;
                        old_q         <= '0;
                        if (dec_illegal) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            count_sel_q <= dec_sel;
                            state_q     <= ST_SEL;
                        end
                    end
                end
                ST_SEL: begin
                    // The counter's read register holds while frozen; wait for a real capture.
                    if (!freeze) begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_q       <= count;
                    count_sel_q <= SEL_IDLE;
                    if (write_needed) begin
                        csr_wr_en_q  <= 1'b1;
                        wr_sel_q     <= sel_q;
                        csr_wrdata_q <= wr_value_d;
                        state_q      <= ST_WRITE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    csr_wr_en_q <= 1'b0;
                    wr_sel_q    <= SEL_IDLE;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = old_q;
    assign rsp_illegal = rsp_illegal_q;
    assign count_sel   = count_sel_q;
    assign wr_sel      = wr_sel_q;
    assign csr_wrdata  = csr_wrdata_q;
    assign csr_wr_en   = csr_wr_en_q;

endmodule

// File: tb/tb_sys_counter_csr_ctrl.sv
// Self-checking bench for sys_counter_csr_ctrl: directed vector table, randomized requests
// against an address-map reference model, and hand-written reset / response-hold sequences.
module tb_sys_counter_csr_ctrl;

    localparam logic [11:0] CBASE      = 12'h7C0;
    localparam bit          USER_RO_ON = 1'b1;

    logic        proc_clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_src_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic        freeze;
    logic [3:0]  count_sel;
    logic [31:0] count = '0;
    logic [3:0]  wr_sel;
    logic [31:0] csr_wrdata;
    logic        csr_wr_en;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 proc_clk = ~proc_clk;

    sys_counter_csr_ctrl #(
        .CUSTOM_BASE (CBASE),
        .USER_RO_EN  (USER_RO_ON)
    ) dut (
        .proc_clk     (proc_clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_src_zero (req_src_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_illegal  (rsp_illegal),
        .freeze       (freeze),
        .count_sel    (count_sel),
        .count        (count),
        .wr_sel       (wr_sel),
        .csr_wrdata   (csr_wrdata),
        .csr_wr_en    (csr_wr_en)
    );

    // Counter block model: registered read that holds under freeze, write strobe ignores freeze.
    logic [31:0] regs [16] = '{default: '0};
    int          wr_pulses = 0;
    logic [3:0]  last_wr_sel = '0;
    logic [31:0] last_wrdata = '0;
    int          sel_seen = 0;
    logic [3:0]  last_sel = '0;

    always @(posedge proc_clk) begin
        if (!freeze) count <= regs[count_sel];
        if (csr_wr_en) begin
            regs[wr_sel] <= (wr_sel == 4'b1100) ? (csr_wrdata & 32'h0001_FFFF) : csr_wrdata;
            wr_pulses    <= wr_pulses + 1;
            last_wr_sel  <= wr_sel;
            last_wrdata  <= csr_wrdata;
        end
    end

    always @(negedge proc_clk) begin
        if (count_sel !== 4'b0010) begin
            sel_seen <= sel_seen + 1;
            last_sel <= count_sel;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Address map reference: list of legal CSR addresses with their select and read-only flag.
    typedef struct {
        logic [11:0] addr;
        logic [3:0]  sel;
        bit          ro;
    } map_t;
    map_t amap[16];

    task automatic ref_lookup(input logic [11:0] addr, output bit found, output logic [3:0] sel,
                              output bit ro);
        found = 1'b0; sel = 4'b0010; ro = 1'b0;
        foreach (amap[i]) begin
            if (!found && amap[i].addr == addr) begin
                found = 1'b1; sel = amap[i].sel; ro = amap[i].ro;
            end
        end
    endtask

    task automatic run_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                           input bit sz, input int frz,
                           output logic [31:0] rdata, output bit ill, output int lat,
                           output int nwr, output logic [3:0] wsel, output logic [31:0] wdat,
                           output int nsel, output logic [3:0] lsel);
        int w0;
        int s0;
        @(negedge proc_clk);
        req_op = op; req_addr = addr; req_wdata = wd; req_src_zero = sz;
        req_valid = 1'b1; freeze = (frz > 0);
        w0 = wr_pulses; s0 = sel_seen;
        @(posedge proc_clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            if (lat > frz) freeze = 1'b0;
            @(posedge proc_clk); #1;
            lat++;
        end
        freeze = 1'b0;
        rdata = rsp_rdata; ill = rsp_illegal;
        @(negedge proc_clk); rsp_ready = 1'b1;
        @(posedge proc_clk); #1; rsp_ready = 1'b0;
        nwr = wr_pulses - w0; wsel = last_wr_sel; wdat = last_wrdata;
        nsel = sel_seen - s0; lsel = last_sel;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        bit          sz;
        int          frz;
        bit          e_ill;
        logic [3:0]  e_csel;
        logic [31:0] e_rdata;
        bit          e_wr;
        logic [31:0] e_wdata;
        int          e_lat;
    } vec_t;
    vec_t vt[16];

    function automatic vec_t mkv(string n, logic [1:0] op, logic [11:0] a, logic [31:0] w, bit sz,
                                 int frz, bit ill, logic [3:0] cs, logic [31:0] rd, bit wr,
                                 logic [31:0] wv, int lat);
        vec_t v;
        v.name = n; v.op = op; v.addr = a; v.wdata = w; v.sz = sz; v.frz = frz;
        v.e_ill = ill; v.e_csel = cs; v.e_rdata = rd; v.e_wr = wr; v.e_wdata = wv; v.e_lat = lat;
        return v;
    endfunction

    logic [31:0] r_rdata;
    bit          r_ill;
    int          r_lat;
    int          r_nwr;
    logic [3:0]  r_wsel;
    logic [31:0] r_wdat;
    int          r_nsel;
    logic [3:0]  r_lsel;

    initial begin
        amap[0]  = '{12'hB00, 4'b0000, 1'b0};  amap[1]  = '{12'hB80, 4'b0001, 1'b0};
        amap[2]  = '{12'hB02, 4'b0100, 1'b0};  amap[3]  = '{12'hB82, 4'b0101, 1'b0};
        amap[4]  = '{12'hC00, 4'b0000, 1'b1};  amap[5]  = '{12'hC80, 4'b0001, 1'b1};
        amap[6]  = '{12'hC01, 4'b1000, 1'b1};  amap[7]  = '{12'hC81, 4'b1001, 1'b1};
        amap[8]  = '{12'hC02, 4'b0100, 1'b1};  amap[9]  = '{12'hC82, 4'b0101, 1'b1};
        amap[10] = '{CBASE + 12'd0, 4'b1010, 1'b0};
        amap[11] = '{CBASE + 12'd1, 4'b1011, 1'b0};
        amap[12] = '{CBASE + 12'd2, 4'b1000, 1'b0};
        amap[13] = '{CBASE + 12'd3, 4'b1001, 1'b0};
        amap[14] = '{CBASE + 12'd4, 4'b1100, 1'b0};
        amap[15] = '{CBASE + 12'd5, 4'b1101, 1'b0};

        //                name           op     addr     wdata         sz frz ill csel     rdata          wr wdata         lat
        vt[0]  = mkv("rw_b00",         2'b01, 12'hB00, 32'h1234_5678, 0, 0, 0, 4'b0000, 32'hA5A5_0001, 1, 32'h1234_5678, 4);
        vt[1]  = mkv("rs_7c1_zero",    2'b10, 12'h7C1, 32'h0,         1, 0, 0, 4'b1011, 32'hFFFF_FFFF, 0, 32'h0,         3);
        vt[2]  = mkv("rc_7c5",         2'b11, 12'h7C5, 32'h0000_00FF, 0, 0, 0, 4'b1101, 32'h0000_FFFF, 1, 32'h0000_FF00, 4);
        vt[3]  = mkv("rw_c01_ill",     2'b01, 12'hC01, 32'h0000_DEAD, 0, 0, 1, 4'b0010, 32'h0,         0, 32'h0,         1);
        vt[4]  = mkv("op00_b00_ill",   2'b00, 12'hB00, 32'h0000_0001, 0, 0, 1, 4'b0010, 32'h0,         0, 32'h0,         1);
        vt[5]  = mkv("freeze5_b00",    2'b10, 12'hB00, 32'h0,         1, 5, 0, 4'b0000, 32'h1234_5678, 0, 32'h0,         8);
        vt[6]  = mkv("rs_c00_ro",      2'b10, 12'hC00, 32'h0,         1, 0, 0, 4'b0000, 32'h1234_5678, 0, 32'h0,         3);
        vt[7]  = mkv("rs_c80_nz_ill",  2'b10, 12'hC80, 32'h0000_0001, 0, 0, 1, 4'b0010, 32'h0,         0, 32'h0,         1);
        vt[8]  = mkv("rw_7c6_unmap",   2'b01, 12'h7C6, 32'h0000_0001, 0, 0, 1, 4'b0010, 32'h0,         0, 32'h0,         1);
        vt[9]  = mkv("rs_7c5_set",     2'b10, 12'h7C5, 32'hF000_0000, 0, 0, 0, 4'b1101, 32'h0000_FF00, 1, 32'hF000_FF00, 4);
        vt[10] = mkv("rw_7c4_tick",    2'b01, 12'h7C4, 32'hFFFF_FFFF, 0, 0, 0, 4'b1100, 32'h0,         1, 32'hFFFF_FFFF, 4);
        vt[11] = mkv("rs_7c4_trunc",   2'b10, 12'h7C4, 32'h0,         1, 0, 0, 4'b1100, 32'h0001_FFFF, 0, 32'h0,         3);
        vt[12] = mkv("rc_b82_zero",    2'b11, 12'hB82, 32'h0,         1, 0, 0, 4'b0101, 32'h0,         0, 32'h0,         3);
        vt[13] = mkv("rc_c81_ro",      2'b11, 12'hC81, 32'h0,         1, 0, 0, 4'b1001, 32'h0,         0, 32'h0,         3);
        vt[14] = mkv("rw_7c2_time",    2'b01, 12'h7C2, 32'h0BAD_BEEF, 0, 0, 0, 4'b1000, 32'h0,         1, 32'h0BAD_BEEF, 4);
        vt[15] = mkv("rs_c01_time",    2'b10, 12'hC01, 32'h0,         1, 0, 0, 4'b1000, 32'h0BAD_BEEF, 0, 32'h0,         3);

        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
        req_src_zero = 1'b0; rsp_ready = 1'b0; freeze = 1'b0;
        repeat (3) @(posedge proc_clk);
        #1;
        check("reset/req_ready",   {31'd0, req_ready},   32'd1);
        check("reset/rsp_valid",   {31'd0, rsp_valid},   32'd0);
        check("reset/rsp_rdata",   rsp_rdata,            32'd0);
        check("reset/rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
        check("reset/count_sel",   {28'd0, count_sel},   32'd2);
        check("reset/wr_sel",      {28'd0, wr_sel},      32'd2);
        check("reset/csr_wrdata",  csr_wrdata,           32'd0);
        check("reset/csr_wr_en",   {31'd0, csr_wr_en},   32'd0);
        @(negedge proc_clk); rst = 1'b0;

        // Preload registers through the DUT itself.
        run_req(2'b01, 12'hB00, 32'hA5A5_0001, 0, 0, r_rdata, r_ill, r_lat, r_nwr, r_wsel, r_wdat, r_nsel, r_lsel);
        run_req(2'b01, 12'h7C1, 32'hFFFF_FFFF, 0, 0, r_rdata, r_ill, r_lat, r_nwr, r_wsel, r_wdat, r_nsel, r_lsel);
        run_req(2'b01, 12'h7C5, 32'h0000_FFFF, 0, 0, r_rdata, r_ill, r_lat, r_nwr, r_wsel, r_wdat, r_nsel, r_lsel);

        foreach (vt[i]) begin
            run_req(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].sz, vt[i].frz,
                    r_rdata, r_ill, r_lat, r_nwr, r_wsel, r_wdat, r_nsel, r_lsel);
            check({vt[i].name, "/illegal"}, {31'd0, r_ill}, {31'd0, vt[i].e_ill});
            check({vt[i].name, "/rdata"}, r_rdata, vt[i].e_rdata);
            check({vt[i].name, "/latency"}, r_lat, vt[i].e_lat);
            check({vt[i].name, "/wr_pulses"}, r_nwr, vt[i].e_wr ? 1 : 0);
            if (vt[i].e_wr) begin
                check({vt[i].name, "/wr_sel"}, {28'd0, r_wsel}, {28'd0, vt[i].e_csel});
                check({vt[i].name, "/csr_wrdata"}, r_wdat, vt[i].e_wdata);
            end
            if (vt[i].e_ill) check({vt[i].name, "/no_count_sel"}, r_nsel, 0);
            else check({vt[i].name, "/count_sel"}, {28'd0, r_lsel}, {28'd0, vt[i].e_csel});
            check({vt[i].name, "/req_ready"}, {31'd0, req_ready}, 32'd1);
        end

        for (int n = 0; n < 150; n++) begin
            logic [11:0] addr;
            logic [1:0]  op;
            logic [31:0] wd;
            logic [31:0] old_val;
            logic [31:0] new_val;
            logic [3:0]  sel;
            bit          sz;
            bit          found;
            bit          ro;
            bit          ill;
            bit          wr;
            int          frz;
            logic [11:0] unmapped [6];
            unmapped = '{12'h7C6, 12'hB01, 12'hC03, 12'h000, 12'h7BF, 12'hB81};
            if ($urandom_range(0, 4) == 0) addr = unmapped[$urandom_range(0, 5)];
            else addr = amap[$urandom_range(0, 15)].addr;
            op  = 2'($urandom_range(0, 3));
            sz  = ($urandom_range(0, 2) == 0);
            wd  = sz ? 32'd0 : $urandom;
            frz = $urandom_range(0, 2);
            ref_lookup(addr, found, sel, ro);
            ill = !found || (op == 2'b00) || (ro && (op == 2'b01 || !sz))
                  || ((addr[11:8] == 4'hC) && !USER_RO_ON);
            wr  = !ill && (op == 2'b01 || !sz);
            old_val = ill ? 32'd0 : regs[sel];
            new_val = (op == 2'b01) ? wd : (op == 2'b10) ? (old_val | wd) : (old_val & ~wd);
            run_req(op, addr, wd, sz, frz, r_rdata, r_ill, r_lat, r_nwr, r_wsel, r_wdat, r_nsel, r_lsel);
            check($sformatf("rand%0d/illegal", n), {31'd0, r_ill}, {31'd0, ill});
            check($sformatf("rand%0d/rdata", n), r_rdata, old_val);
            check($sformatf("rand%0d/wr_pulses", n), r_nwr, wr ? 1 : 0);
            check($sformatf("rand%0d/latency", n), r_lat, ill ? 1 : (wr ? 4 : 3) + frz);
            if (wr) begin
                check($sformatf("rand%0d/wr_sel", n), {28'd0, r_wsel}, {28'd0, sel});
                check($sformatf("rand%0d/csr_wrdata", n), r_wdat, new_val);
            end
            if (ill) check($sformatf("rand%0d/no_count_sel", n), r_nsel, 0);
            else check($sformatf("rand%0d/count_sel", n), {28'd0, r_lsel}, {28'd0, sel});
        end

        // Response held: rsp_valid stays up and a new request is not accepted.
        begin
            int w0;
            int s0;
            int bad;
            int lat;
            @(negedge proc_clk);
            req_op = 2'b10; req_addr = 12'hB00; req_wdata = '0; req_src_zero = 1'b1; req_valid = 1'b1;
            @(posedge proc_clk); #1; req_valid = 1'b0;
            lat = 1;
            while (!rsp_valid && lat < 20) begin @(posedge proc_clk); #1; lat++; end
            check("hold/latency", lat, 3);
            @(negedge proc_clk);
            req_op = 2'b01; req_addr = 12'hB80; req_wdata = 32'h55; req_src_zero = 1'b0; req_valid = 1'b1;
            w0 = wr_pulses; s0 = sel_seen; bad = 0;
            repeat (5) begin
                @(posedge proc_clk); #1;
                if (!rsp_valid || req_ready) bad++;
            end
            check("hold/rsp_valid_held", bad, 0);
            check("hold/no_new_write", wr_pulses - w0, 0);
            check("hold/no_new_select", sel_seen - s0, 0);
            @(negedge proc_clk); req_valid = 1'b0; rsp_ready = 1'b1;
            @(posedge proc_clk); #1; rsp_ready = 1'b0;
            check("hold/released", {30'd0, rsp_valid, req_ready}, 32'd1);
        end

        // Reset during WRITE: outputs clear at once, write dropped, no response.
        begin
            int          n;
            int          w0;
            int          seen;
            logic [31:0] saved;
            saved = regs[4];
            @(negedge proc_clk);
            req_op = 2'b01; req_addr = 12'hB02; req_wdata = 32'hCAFE_F00D; req_src_zero = 1'b0;
            req_valid = 1'b1;
            @(posedge proc_clk); #1; req_valid = 1'b0;
            n = 0;
            while (!csr_wr_en && n < 10) begin @(posedge proc_clk); #1; n++; end
            check("rst/reached_write", {31'd0, csr_wr_en}, 32'd1);
            w0 = wr_pulses;
            #2 rst = 1'b1;
            #1;
            check("rst/req_ready",   {31'd0, req_ready},   32'd1);
            check("rst/rsp_valid",   {31'd0, rsp_valid},   32'd0);
            check("rst/rsp_rdata",   rsp_rdata,            32'd0);
            check("rst/rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
            check("rst/count_sel",   {28'd0, count_sel},   32'd2);
            check("rst/wr_sel",      {28'd0, wr_sel},      32'd2);
            check("rst/csr_wrdata",  csr_wrdata,           32'd0);
            check("rst/csr_wr_en",   {31'd0, csr_wr_en},   32'd0);
            @(negedge proc_clk); rst = 1'b0;
            seen = 0;
            repeat (6) begin
                @(posedge proc_clk); #1;
                if (rsp_valid) seen++;
            end
            check("rst/no_response", seen, 0);
            check("rst/write_dropped", wr_pulses - w0, 0);
            check("rst/reg_unchanged", regs[4], saved);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_counter_csr_ctrl.md
Name: sys_counter_csr_ctrl

Overview:
- Upstream sequencer between the CSR execute stage and the system counter block.
- Accepts one CSR instruction (RW/RS/RC) on a valid/ready handshake and decodes the 12-bit CSR address into the counter's 4-bit select code.
- Reads the registered count, computes the read-modify-write value, issues a single write strobe, and returns the old value with an illegal flag.
- Serializes all counter accesses: one request in flight at a time.

Parameters:
- CUSTOM_BASE, 12'h7C0, base address of the custom machine-RW window (+0 timecmp, +1 timecmph, +2 time, +3 timeh, +4 tick counter, +5 tick limit)
- USER_RO_EN, 1, when 1, user read-only aliases 0xC00/C01/C02/C80/C81/C82 are legal for reads

Ports:
- proc_clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  CSR request present
- req_ready  out  1  high only in IDLE
- req_op  in  2  01 RW, 10 RS, 11 RC, 00 illegal
- req_addr  in  12  CSR address
- req_wdata  in  32  rs1 value or zimm
- req_src_zero  in  1  rs1 is x0 / zimm==0 (suppresses write for RS/RC)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  old CSR value (0 if illegal)
- rsp_illegal  out  1  raise illegal-instruction trap
- freeze  in  1  pipeline freeze (counter read register holds while high)
- count_sel  out  4  to counter block
- count  in  32  registered read data from counter block
- wr_sel  out  4  to counter block
- csr_wrdata  out  32  to counter block
- csr_wr_en  out  1  one-cycle write strobe

Behaviour:
- Select encoding (read and write):
  - 0000 cycle lo, 0001 cycle hi
  - 0100 instret lo, 0101 instret hi
  - 1000 time lo, 1001 time hi
  - 1010 timecmp lo, 1011 timecmp hi
  - 1100 tick counter, 1101 tick limit
- Address map:
  - 0xB00/B80 -> 0000/0001 (RW); 0xB02/B82 -> 0100/0101 (RW).
  - 0xC00/C80, 0xC01/C81, 0xC02/C82 -> cycle/time/instret lo/hi, read-only.
  - Custom window maps in order to 1010, 1011, 1000, 1001, 1100, 1101 (RW).
- Idle drive values:
  - count_sel = wr_sel = 4'b0010 (bit1 set, so no counter sees a read stall).
  - csr_wr_en = 0.
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_illegal=0, csr_wrdata=0, selects at idle values.
- Illegal when any of:
  - unmapped address;
  - op==00;
  - read-only address with RW;
  - read-only address with RS/RC and !req_src_zero;
  - C-range address with USER_RO_EN==0.
- FSM:
  - IDLE: accept on req_valid. Latch op, sel, wdata, src_zero, illegal. Illegal -> RESP with rdata=0, no counter access. Legal -> SEL.
  - SEL: drive count_sel=sel. Stay while freeze=1. Leave at the first edge with freeze=0 -> READ.
  - READ: count now valid; capture it into old_q. Compute new value: RW: wdata; RS: old|wdata; RC: old&~wdata. Write needed = RW, or RS/RC with !src_zero. Write needed -> WRITE, else RESP.
  - WRITE: exactly one cycle; csr_wr_en=1, wr_sel=sel, csr_wrdata=new. -> RESP.
  - RESP: rsp_valid=1, rsp_rdata=old_q. Leave to IDLE on rsp_ready.
- Latency from accept edge to rsp_valid: 3 cycles without a write, 4 with a write, plus freeze cycles.
- count_sel returns to idle outside SEL/READ.
- The write path ignores freeze.
- Tick-counter writes pass all 32 bits; the counter block truncates to 17.
- Reset mid-operation: return to IDLE immediately; any in-progress write is dropped; no response is produced.

Decomposition:
- Package sys_counter_csr_pkg:
  - CSR address constants;
  - 4-bit select codes;
  - op codes;
  - FSM state enum (IDLE, SEL, READ, WRITE, RESP).
- One combinational sub-module sys_counter_csr_decode: addr, op, src_zero -> sel, writable, illegal.

Test Plan:
- RW 0xB00, wdata=0x1234_5678 -> count_sel=0000 in SEL; one csr_wr_en pulse with wr_sel=0000, csr_wrdata=0x12345678; rsp_rdata=prior cycle lo; total latency 4.
- RS 0x7C1 with src_zero=1, timecmph=0xFFFFFFFF -> no csr_wr_en; rsp_rdata=0xFFFFFFFF; latency 3.
- RC 0x7C5, wdata=0x00FF, old tick limit 0xFFFF -> csr_wrdata=0xFF00, wr_sel=1101, rsp_rdata=0x0000FFFF.
- RW 0xC01 -> rsp_illegal=1, rsp_rdata=0, no count_sel change, no csr_wr_en; also op=00 to 0xB00 -> illegal.
- freeze held for 5 cycles in SEL -> FSM stays in SEL; rdata equals count after freeze drops; latency grows by 5.
- rst asserted during WRITE, then rsp_ready held low in RESP -> reset: outputs return to reset values asynchronously, no rsp_valid. Held rsp_ready: rsp_valid stays high, req_ready stays low, and a new req_valid is not accepted.
